de270_sysid_checker: RTL

//  Avalon-MM master that reads the system-ID slave after reset (or on request) and checks it.

---
 rtl/de270_sysid_checker_pkg.sv | 25 ++
 rtl/de270_wait_timer.sv | 51 +++++
 rtl/de270_sysid_checker.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/de270_sysid_checker_pkg.sv
// rtl/de270_sysid_checker_pkg.sv - shared definitions for the sysid checker and its wait timer
// Contents: FSM state encodings (3-bit), sysid word addresses, default expected
// ID/timestamp constants, and the timer width helper.
package de270_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1385403304;

  // Counter width able to hold 0..limit; a disabled (0) limit still gets one bit.
  function automatic int timer_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/de270_wait_timer.sv
// rtl/de270_wait_timer.sv - saturating stall timer for Avalon-MM masters
// Ports:
//   clock   in  1  system clock
//   reset   in  1  synchronous active-high reset, clears the count
//   enable  in  1  count this cycle (master is stalled)
//   clear   in  1  restart counting from 0; wins over enable
//   expired out 1  this enabled cycle brings the count to LIMIT
// LIMIT = 0 disables the timer: it never counts and never expires.
module de270_wait_timer
  import de270_sysid_checker_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int W = timer_width(LIMIT);
  localparam logic [W-1:0] LIM_W  = W'(LIMIT);
  localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (LIMIT != 0) && (count_q != LIM_W)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Flag the stalled cycle that completes the LIMIT-th wait, so the master can
  // drop its request on the same edge instead of one cycle late.
  always_comb begin
    expired = (LIMIT != 0) && enable && (count_q >= LIM_M1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/de270_sysid_checker.sv
// rtl/de270_sysid_checker.sv - Avalon-MM master that reads and checks the sysid slave
// Ports:
//   clock, reset            system clock; synchronous active-high reset
//   start                   one-cycle check request, ignored while busy
//   avm_address/avm_read    registered Avalon-MM read request (0 = ID, 1 = timestamp)
//   avm_readdata/waitrequest slave read data and stall
//   busy/done/pass          check progress and overall result
//   id_ok/ts_ok/timeout_err per-word match flags and timeout abort flag
//   id_value/ts_value       captured sysid words
module de270_sysid_checker
  import de270_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        first_q, first_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic timer_en;
  logic timer_clr;
  logic timer_expired;
  logic accept;
  logic start_req;

  de270_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (timer_en),
    .clear   (timer_clr),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;
    ts_value_d    = ts_value_q;
    timer_clr     = 1'b0;

    accept    = avm_read_q && !avm_waitrequest;
    timer_en  = avm_read_q && avm_waitrequest;
    // first_q is only high on the first cycle out of reset.
    start_req = start || ((AUTO_START != 0) && first_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_req) begin
          state_d       = ST_RD_ID;
          avm_read_d    = 1'b1;
          avm_address_d = SYSID_ADDR_ID;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
          timer_clr     = 1'b1;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        if (accept) begin
          timer_clr = 1'b1;
          if (state_q == ST_RD_ID) begin
            id_value_d    = avm_readdata;
            avm_address_d = SYSID_ADDR_TS;
            state_d       = ST_RD_TS;
          end else begin
            ts_value_d = avm_readdata;
            avm_read_d = 1'b0;
            state_d    = ST_CMP;
          end
        end else if (timer_expired) begin
          // Abort: the word still outstanding keeps its previous captured value.
          timer_clr     = 1'b1;
          avm_read_d    = 1'b0;
          state_d       = ST_DONE;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          pass_d        = 1'b0;
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      ST_CMP: begin
        id_ok_d = (id_value_q == EXPECTED_ID);
        ts_ok_d = (ts_value_q == EXPECTED_TS);
        pass_d  = (id_value_q == EXPECTED_ID) && (ts_value_q == EXPECTED_TS);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      default: begin
        state_d    = ST_IDLE;
        avm_read_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      first_q       <= 1'b1;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= 32'd0;
      ts_value_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
